// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with valid/ready on both request and result sides.
// Latency: 1 cycle for ADD/SUB/AND/OR/XOR/SLT/SHL-by-0, amount+1 for SHL, N+1 for MUL.
// Backpressure: a result is held in DONE until i_ready; a new request is accepted only in IDLE or on the consuming cycle.
module alu_seq #(
    parameter int N = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [2:0]   i_op,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] o_result,
    output logic         o_carry,
    output logic         o_zero,
    output logic         o_neg,
    output logic         o_ovf
);

    localparam int SW = $clog2(N);
    localparam int CW = SW + 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            is_mul_q, is_mul_d;   // BUSY is running MUL (else SHL)
    logic [N-1:0]    opnd_q, opnd_d;       // multiplicand, or the value being shifted
    logic [2*N-1:0]  acc_q, acc_d;         // {partial product high, remaining multiplier}
    logic [CW-1:0]   cnt_q, cnt_d;         // BUSY steps left, including the current one
    logic            shcy_q, shcy_d;       // OR of bits shifted out so far
    logic [N-1:0]    res_q, res_d;
    logic            cy_q, cy_d;
    logic            ovf_q, ovf_d;

    logic [N:0]      add_w;
    logic [N:0]      sub_w;
    logic [SW-1:0]   sh_amt;
    logic [N-1:0]    fast_res;
    logic            fast_cy;
    logic            fast_ovf;
    logic [N:0]      mul_sum;
    logic [2*N-1:0]  mul_next;
    logic [N-1:0]    shl_next;
    logic            shl_cy_next;
    logic            last_step;
    logic            accept;

    // Single-cycle datapath evaluated on the incoming operands at acceptance.
    always_comb begin
        add_w    = {1'b0, i_a} + {1'b0, i_b};
        sub_w    = {1'b0, i_a} + {1'b0, ~i_b} + (N+1)'(1);
        sh_amt   = i_b[SW-1:0];
        fast_res = '0;
        fast_cy  = 1'b0;
        fast_ovf = 1'b0;
        case (i_op)
            OP_ADD: begin
                fast_res = add_w[N-1:0];
                fast_cy  = add_w[N];
                fast_ovf = (i_a[N-1] == i_b[N-1]) && (add_w[N-1] != i_a[N-1]);
            end
            OP_SUB: begin
                fast_res = sub_w[N-1:0];
                fast_cy  = sub_w[N];
                fast_ovf = (i_a[N-1] != i_b[N-1]) && (sub_w[N-1] != i_a[N-1]);
            end
            OP_AND: fast_res = i_a & i_b;
            OP_OR:  fast_res = i_a | i_b;
            OP_XOR: fast_res = i_a ^ i_b;
            OP_SLT: fast_res = {{(N-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            // Only reached as a fast op when the shift amount is zero.
            OP_SHL: fast_res = i_a;
            default: fast_res = '0;
        endcase
    end

    // One BUSY step of the iterative ops: shift-add multiply and shift-left.
    always_comb begin
        mul_sum     = {1'b0, acc_q[2*N-1:N]} + {1'b0, (acc_q[0] ? opnd_q : {N{1'b0}})};
        mul_next    = {mul_sum, acc_q[N-1:1]};
        shl_next    = {opnd_q[N-2:0], 1'b0};
        shl_cy_next = shcy_q | opnd_q[N-1];
        last_step   = (cnt_q == CW'(1));
    end

    // Handshake, next-state and datapath register updates.
    always_comb begin
        state_d  = state_q;
        is_mul_d = is_mul_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        shcy_d   = shcy_q;
        res_d    = res_q;
        cy_d     = cy_q;
        ovf_d    = ovf_q;

        o_ready  = (state_q == IDLE) || ((state_q == DONE) && i_ready);
        accept   = i_valid && o_ready;

        case (state_q)
            BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (is_mul_q) begin
                    acc_d = mul_next;
                    if (last_step) begin
                        res_d   = mul_next[N-1:0];
                        cy_d    = |mul_next[2*N-1:N];
                        ovf_d   = 1'b0;
                        state_d = DONE;
                    end
                end else begin
                    opnd_d = shl_next;
                    shcy_d = shl_cy_next;
                    if (last_step) begin
                        res_d   = shl_next;
                        cy_d    = shl_cy_next;
                        ovf_d   = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (i_ready && !i_valid) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

        if (accept) begin
            if (i_op == OP_MUL) begin
                is_mul_d = 1'b1;
                opnd_d   = i_a;
                acc_d    = {{N{1'b0}}, i_b};
                cnt_d    = CW'(N);
                state_d  = BUSY;
            end else if ((i_op == OP_SHL) && (sh_amt != '0)) begin
                is_mul_d = 1'b0;
                opnd_d   = i_a;
                shcy_d   = 1'b0;
                cnt_d    = {1'b0, sh_amt};
                state_d  = BUSY;
            end else begin
                res_d    = fast_res;
                cy_d     = fast_cy;
                ovf_d    = fast_ovf;
                state_d  = DONE;
            end
        end
    end

    // State and datapath registers; reset drops any operation in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            is_mul_q <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            shcy_q   <= 1'b0;
            res_q    <= '0;
            cy_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_mul_q <= is_mul_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            shcy_q   <= shcy_d;
            res_q    <= res_d;
            cy_q     <= cy_d;
            ovf_q    <= ovf_d;
        end
    end

    // Result and flags are only visible while valid; zero otherwise.
    always_comb begin
        o_valid  = (state_q == DONE);
        o_result = o_valid ? res_q : '0;
        o_carry  = o_valid & cy_q;
        o_ovf    = o_valid & ovf_q;
        o_zero   = o_valid & (res_q == '0);
        o_neg    = o_valid & res_q[N-1];
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq with a queue-based scoreboard.
// Driver pushes expected results at acceptance; monitor pops on each result handshake.
// Also checks result latency from acceptance and zeroed outputs while not valid.
module tb_alu_seq;
    localparam int N = 8;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_valid = 1'b0;
    logic         o_ready;
    logic [N-1:0] i_a = '0;
    logic [N-1:0] i_b = '0;
    logic [2:0]   i_op = '0;
    logic         o_valid;
    logic         i_ready = 1'b1;
    logic [N-1:0] o_result;
    logic         o_carry, o_zero, o_neg, o_ovf;

    alu_seq #(.N(N)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_a(i_a), .i_b(i_b), .i_op(i_op), .o_valid(o_valid), .i_ready(i_ready),
        .o_result(o_result), .o_carry(o_carry), .o_zero(o_zero), .o_neg(o_neg), .o_ovf(o_ovf)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [N-1:0] res;
        logic         c, z, n, v;
        int           acc_cyc;
        int           lat;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   rise_cyc = 0;
    logic prev_valid = 1'b0;
    logic prev_hs = 1'b0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compare each consumed result against the oldest expectation.
    always @(negedge i_clk) begin
        automatic int   rc = rise_cyc;
        automatic exp_t e;
        if (i_rst) begin
            prev_valid <= 1'b0;
            prev_hs    <= 1'b0;
        end else begin
            if (o_valid && (!prev_valid || prev_hs)) rc = cyc;
            rise_cyc <= rc;
            if (!o_valid)
                chk("idle_outputs_zero", {o_result, o_carry, o_zero, o_neg, o_ovf}, 32'h0);
            if (o_valid && i_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_result", o_result, 32'hFFFF_FFFF);
                end else begin
                    e = sbq.pop_front();
                    chk("result", o_result, e.res);
                    chk("flags_czn v", {o_carry, o_zero, o_neg, o_ovf}, {e.c, e.z, e.n, e.v});
                    chk("latency", rc - e.acc_cyc, e.lat);
                end
            end
            prev_valid <= o_valid;
            prev_hs    <= o_valid && i_ready;
        end
    end

    task automatic issue(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] r, input logic c, input logic z, input logic n,
                         input logic v, input int lat, input bit push);
        exp_t e;
        i_op = op; i_a = a; i_b = b; i_valid = 1'b1;
        for (int t = 0; t < 60; t++) begin
            @(negedge i_clk);
            if (o_ready) break;
        end
        chk("accept_wait", o_ready, 1);
        if (push) begin
            e.res = r; e.c = c; e.z = z; e.n = n; e.v = v;
            e.acc_cyc = cyc; e.lat = lat;
            sbq.push_back(e);
        end
        @(posedge i_clk); #1;
        // Scramble inputs after acceptance: the DUT must work from latched copies.
        i_valid = 1'b0;
        i_a = N'($urandom); i_b = N'($urandom); i_op = 3'($urandom);
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && sbq.size() != 0; t++) @(negedge i_clk);
        chk("drain", sbq.size(), 0);
        @(posedge i_clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        chk("reset_state", {o_valid, o_ready, o_result, o_carry, o_zero, o_neg, o_ovf},
            {1'b0, 1'b1, 8'h00, 4'b0000});
        @(posedge i_clk); #1;

        //    op      a      b      res    c  z  n  v  lat
        issue(3'b000, 8'hBD, 8'hA5, 8'h62, 1, 0, 0, 1, 1, 1);   // ADD
        issue(3'b001, 8'hBD, 8'hA5, 8'h18, 1, 0, 0, 0, 1, 1);   // SUB
        issue(3'b101, 8'hBD, 8'hA5, 8'h00, 0, 1, 0, 0, 1, 1);   // SLT
        issue(3'b010, 8'hBD, 8'hA5, 8'hA5, 0, 0, 1, 0, 1, 1);   // AND
        issue(3'b011, 8'hBD, 8'hA5, 8'hBD, 0, 0, 1, 0, 1, 1);   // OR
        issue(3'b100, 8'hBD, 8'hA5, 8'h18, 0, 0, 0, 0, 1, 1);   // XOR
        issue(3'b001, 8'h00, 8'h01, 8'hFF, 0, 0, 1, 0, 1, 1);   // SUB borrow
        issue(3'b001, 8'h80, 8'h01, 8'h7F, 1, 0, 0, 1, 1, 1);   // SUB overflow
        issue(3'b000, 8'h7F, 8'h01, 8'h80, 0, 0, 1, 1, 1, 1);   // ADD overflow
        issue(3'b101, 8'h80, 8'h7F, 8'h01, 0, 0, 0, 0, 1, 1);   // SLT true

        issue(3'b111, 8'h0D, 8'h0B, 8'h8F, 0, 0, 1, 0, 9, 1);   // MUL
        for (int i = 0; i < N; i++) begin
            @(negedge i_clk);
            chk("mul_busy_not_ready", {o_ready, o_valid}, 2'b00);
        end
        @(posedge i_clk); #1;
        issue(3'b111, 8'h10, 8'h20, 8'h00, 1, 1, 0, 0, 9, 1);   // MUL high bits only

        issue(3'b110, 8'h81, 8'h03, 8'h08, 1, 0, 0, 0, 4, 1);   // SHL by 3
        issue(3'b110, 8'h81, 8'h00, 8'h81, 0, 0, 1, 0, 1, 1);   // SHL by 0
        issue(3'b110, 8'h01, 8'h0F, 8'h80, 0, 0, 1, 0, 8, 1);   // SHL by 7 (b[2:0])
        issue(3'b110, 8'hFF, 8'h0C, 8'hF0, 1, 0, 1, 0, 5, 1);   // SHL by 4
        drain();

        // Backpressure: result held, new request refused until i_ready rises.
        i_ready = 1'b0;
        issue(3'b000, 8'h03, 8'h04, 8'h07, 0, 0, 0, 0, 1, 1);
        i_op = 3'b001; i_a = 8'h55; i_b = 8'h22; i_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            chk("bp_hold", {o_valid, o_ready, o_result}, {1'b1, 1'b0, 8'h07});
        end
        @(posedge i_clk); #1;
        i_ready = 1'b1;
        @(negedge i_clk);
        chk("bp_release_ready", o_ready, 1);
        begin
            automatic exp_t e;
            e.res = 8'h33; e.c = 1; e.z = 0; e.n = 0; e.v = 0; e.acc_cyc = cyc; e.lat = 1;
            sbq.push_back(e);
        end
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        drain();

        // Reset in the third BUSY cycle of a MUL discards it.
        issue(3'b111, 8'h0D, 8'h0B, 8'h00, 0, 0, 0, 0, 0, 0);
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("abort_state", {o_valid, o_ready, o_result}, {1'b0, 1'b1, 8'h00});
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            chk("abort_no_result", o_valid, 0);
        end
        @(posedge i_clk); #1;
        issue(3'b000, 8'h01, 8'hFF, 8'h00, 1, 1, 0, 0, 1, 1);   // ADD after reset
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
